// File: rtl/obj_affine_walker.sv
// Affine OBJ scanline walker: fetches PA..PD from OAM, sets up the
// texture accumulators with one shared multiplier, then streams pixels.
// Ports:
//   clock, reset          sole clock, synchronous active-high reset
//   start, param_idx      begin a scanline, affine parameter group
//   objx, objy, row       OBJ origin and current scanline
//   hsize, vsize, dblsize sprite size and double-size bounding box
//   oam_addr/rd/rdata     OAM halfword read port, data one cycle later
//   pix_valid/ready       pixel stream handshake
//   pix_col, tex_x/y      screen column and texel coordinate
//   pix_transparent       texel lies outside the sprite
//   busy, done            activity flag and end-of-line pulse
module obj_affine_walker (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  param_idx,
    input  logic [8:0]  objx,
    input  logic [7:0]  objy,
    input  logic [7:0]  row,
    input  logic [7:0]  hsize,
    input  logic [7:0]  vsize,
    input  logic        dblsize,
    output logic [8:0]  oam_addr,
    output logic        oam_rd,
    input  logic [15:0] oam_rdata,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [8:0]  pix_col,
    output logic [5:0]  tex_x,
    output logic [5:0]  tex_y,
    output logic        pix_transparent,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_INIT, S_WALK, S_DONE
    } state_t;

    state_t             r_state;
    logic [2:0]         r_cnt;
    logic [8:0]         r_base;
    logic [8:0]         r_objx;
    logic [7:0]         r_hsize;
    logic [7:0]         r_vsize;
    logic [8:0]         r_bw;
    logic signed [9:0]  r_dx0;
    logic signed [9:0]  r_dy;
    logic [15:0]        r_pa;
    logic [15:0]        r_pb;
    logic [15:0]        r_pc;
    logic [15:0]        r_pd;
    logic [23:0]        r_ax;
    logic [23:0]        r_ay;
    logic [8:0]         r_i;
    logic [8:0]         r_col;
    logic [8:0]         r_oam_addr;
    logic               r_oam_rd;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    // Bounding-box geometry from the live inputs, latched on start.
    logic [8:0]         w_bw;
    logic [8:0]         w_bh;
    logic [7:0]         w_rowd;
    logic signed [9:0]  w_dx0;
    logic signed [9:0]  w_dy;
    logic [8:0]         w_base;

    assign w_bw   = {1'b0, hsize} << dblsize;
    assign w_bh   = {1'b0, vsize} << dblsize;
    assign w_rowd = row - objy;
    assign w_dx0  = 10'sd0 - $signed({2'b0, w_bw[8:1]});
    assign w_dy   = $signed({2'b0, w_rowd}) - $signed({2'b0, w_bh[8:1]});
    assign w_base = {param_idx[3:0], 5'd0};

    // Single multiplier; INIT step selects the operand pair.
    logic signed [15:0] w_ma;
    logic signed [9:0]  w_mb;
    logic signed [23:0] w_ea;
    logic signed [23:0] w_eb;
    logic [23:0]        w_prod;

    always_comb begin
        w_ma = r_pd;
        unique case (r_cnt[1:0])
            2'd0:    w_ma = r_pa;
            2'd1:    w_ma = r_pb;
            2'd2:    w_ma = r_pc;
            default: w_ma = r_pd;
        endcase
    end

    assign w_mb   = r_cnt[0] ? r_dy : r_dx0;
    assign w_ea   = 24'(w_ma);
    assign w_eb   = 24'(w_mb);
    assign w_prod = w_ea * w_eb;

    logic [23:0] w_offh;
    logic [23:0] w_offv;
    logic        w_trans;

    assign w_offh  = {9'd0, r_hsize[7:1], 8'd0};
    assign w_offv  = {9'd0, r_vsize[7:1], 8'd0};
    assign w_trans = r_ax[23] | r_ay[23]
                   | (r_ax[23:8] >= {8'd0, r_hsize})
                   | (r_ay[23:8] >= {8'd0, r_vsize});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_base     <= '0;
            r_objx     <= '0;
            r_hsize    <= '0;
            r_vsize    <= '0;
            r_bw       <= '0;
            r_dx0      <= '0;
            r_dy       <= '0;
            r_pa       <= '0;
            r_pb       <= '0;
            r_pc       <= '0;
            r_pd       <= '0;
            r_ax       <= '0;
            r_ay       <= '0;
            r_i        <= '0;
            r_col      <= '0;
            r_oam_addr <= '0;
            r_oam_rd   <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_base  <= w_base;
                        r_objx  <= objx;
                        r_hsize <= hsize;
                        r_vsize <= vsize;
                        r_bw    <= w_bw;
                        r_dx0   <= w_dx0;
                        r_dy    <= w_dy;
                    end
                end
                S_FETCH: begin
                    r_cnt <= r_cnt + 3'd1;
                    // Addresses lead the captured data by two edges.
                    unique case (r_cnt)
                        3'd0: begin
                            r_oam_rd   <= 1'b1;
                            r_oam_addr <= r_base + 9'd3;
                        end
                        3'd1: r_oam_addr <= r_base + 9'd7;
                        3'd2: begin
                            r_oam_addr <= r_base + 9'd11;
                            r_pa       <= oam_rdata;
                        end
                        3'd3: begin
                            r_oam_addr <= r_base + 9'd15;
                            r_pb       <= oam_rdata;
                        end
                        3'd4: begin
                            r_oam_rd   <= 1'b0;
                            r_oam_addr <= '0;
                            r_pc       <= oam_rdata;
                        end
                        default: begin
                            r_pd    <= oam_rdata;
                            r_state <= S_INIT;
                            r_cnt   <= '0;
                        end
                    endcase
                end
                S_INIT: begin
                    r_cnt <= r_cnt + 3'd1;
                    unique case (r_cnt[1:0])
                        2'd0: r_ax <= w_prod + w_offh;
                        2'd1: r_ax <= r_ax + w_prod;
                        2'd2: r_ay <= w_prod + w_offv;
                        default: begin
                            r_ay    <= r_ay + w_prod;
                            r_state <= S_WALK;
                            r_valid <= 1'b1;
                            r_i     <= '0;
                            r_col   <= r_objx;
                            r_cnt   <= '0;
                        end
                    endcase
                end
                S_WALK: begin
                    if (r_valid && pix_ready) begin
                        if (r_i == r_bw - 9'd1) begin
                            r_valid <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_i   <= r_i + 9'd1;
                            r_col <= r_col + 9'd1;
                            r_ax  <= r_ax + {{8{r_pa[15]}}, r_pa};
                            r_ay  <= r_ay + {{8{r_pc[15]}}, r_pc};
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oam_addr        = r_oam_addr;
    assign oam_rd          = r_oam_rd;
    assign pix_valid       = r_valid;
    assign pix_col         = r_col & {9{r_valid}};
    assign tex_x           = r_ax[13:8] & {6{r_valid}};
    assign tex_y           = r_ay[13:8] & {6{r_valid}};
    assign pix_transparent = w_trans & r_valid;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_obj_affine_walker.sv
// Scoreboard bench for obj_affine_walker: arithmetic reference model,
// randomized parameters and backpressure, directed corner cases.
module tb_obj_affine_walker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  param_idx = '0;
    logic [8:0]  objx = '0;
    logic [7:0]  objy = '0;
    logic [7:0]  row = '0;
    logic [7:0]  hsize = 8'd8;
    logic [7:0]  vsize = 8'd8;
    logic        dblsize = 1'b0;
    logic [8:0]  oam_addr;
    logic        oam_rd;
    logic [15:0] oam_rdata = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [8:0]  pix_col;
    logic [5:0]  tex_x;
    logic [5:0]  tex_y;
    logic        pix_transparent;
    logic        busy;
    logic        done;

    obj_affine_walker dut (
        .clock(clock), .reset(reset), .start(start),
        .param_idx(param_idx), .objx(objx), .objy(objy), .row(row),
        .hsize(hsize), .vsize(vsize), .dblsize(dblsize),
        .oam_addr(oam_addr), .oam_rd(oam_rd), .oam_rdata(oam_rdata),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_col(pix_col), .tex_x(tex_x), .tex_y(tex_y),
        .pix_transparent(pix_transparent), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int col;
        int tx;
        int ty;
        int tr;
    } pix_t;

    pix_t        exp_pix[$];
    int          exp_addr[$];
    logic [15:0] mem [512];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          acc_cnt = 0;
    int          rmode = 0;
    int          stall = 0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) oam_rdata <= mem[oam_addr];

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint w24(input longint v);
        longint t;
        t = v % 16777216;
        if (t < 0) t += 16777216;
        if (t >= 8388608) t -= 16777216;
        return t;
    endfunction

    function automatic longint s16(input logic [15:0] v);
        longint t;
        t = longint'(v);
        if (t >= 32768) t -= 65536;
        return t;
    endfunction

    function automatic int texc(input longint a);
        longint t;
        t = a % 16384;
        if (t < 0) t += 16384;
        return int'(t / 256);
    endfunction

    // Reference: geometry and accumulators from the plain formulas.
    task automatic model(input int idx, input int ox, input int oy, input int rw,
                         input int hs, input int vs, input int dbl);
        longint pa, pb, pc, pd, ax, ay, axi, ayi;
        int base, bw, bh, dx0, dy;
        pix_t p;
        base = 32 * idx;
        for (int k = 0; k < 4; k++) exp_addr.push_back((base + 3 + 4 * k) % 512);
        pa  = s16(mem[(base + 3) % 512]);
        pb  = s16(mem[(base + 7) % 512]);
        pc  = s16(mem[(base + 11) % 512]);
        pd  = s16(mem[(base + 15) % 512]);
        bw  = dbl ? 2 * hs : hs;
        bh  = dbl ? 2 * vs : vs;
        dx0 = -(bw / 2);
        dy  = (((rw - oy) % 256) + 256) % 256 - bh / 2;
        ax  = w24(pa * dx0 + pb * dy + (hs / 2) * 256);
        ay  = w24(pc * dx0 + pd * dy + (vs / 2) * 256);
        for (int i = 0; i < bw; i++) begin
            axi   = w24(ax + i * pa);
            ayi   = w24(ay + i * pc);
            p.col = (ox + i) % 512;
            p.tx  = texc(axi);
            p.ty  = texc(ayi);
            p.tr  = (axi < 0 || ayi < 0 || axi / 256 >= hs || ayi / 256 >= vs) ? 1 : 0;
            exp_pix.push_back(p);
        end
    endtask

    task automatic launch(input int idx, input int ox, input int oy, input int rw,
                          input int hs, input int vs, input int dbl);
        @(negedge clock);
        param_idx = 5'(idx);
        objx      = 9'(ox);
        objy      = 8'(oy);
        row       = 8'(rw);
        hsize     = 8'(hs);
        vsize     = 8'(vs);
        dblsize   = 1'(dbl);
        model(idx, ox, oy, rw, hs, vs, dbl);
        acc_cnt = 0;
        stall   = 0;
        start   = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic finish_run(input bit timing, input int bw);
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (pix_valid) break;
        end
        chk("first_valid_seen", pix_valid, 1);
        if (timing) chk("first_valid_cycle", cyc - t0, 10);
        for (int k = 0; k < 3000; k++) begin
            if (done) break;
            @(negedge clock);
        end
        chk("done_seen", done, 1);
        if (timing) chk("done_cycle", cyc - t0, 11 + bw);
        chk("pix_queue_drained", exp_pix.size(), 0);
        chk("addr_queue_drained", exp_addr.size(), 0);
        @(negedge clock);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {oam_addr, oam_rd, pix_valid, pix_col, tex_x, tex_y,
                 pix_transparent, busy, done}, 0);
    endtask

    task automatic set_group(input int idx, input int pa, input int pb,
                             input int pc, input int pd);
        mem[(32 * idx + 3) % 512]  = 16'(pa);
        mem[(32 * idx + 7) % 512]  = 16'(pb);
        mem[(32 * idx + 11) % 512] = 16'(pc);
        mem[(32 * idx + 15) % 512] = 16'(pd);
    endtask

    // Ready driver, updated mid-cycle away from both edges.
    initial forever begin
        @(posedge clock);
        #2;
        case (rmode)
            1: pix_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (pix_valid && acc_cnt == 2 && stall < 3) begin
                    pix_ready = 1'b0;
                    stall++;
                end else begin
                    pix_ready = 1'b1;
                end
            end
            default: pix_ready = 1'b1;
        endcase
    end

    // Monitor: OAM addresses, hold stability, accepted pixels.
    logic [22:0] saved = '0;
    logic        hold_prev = 1'b0;
    pix_t        mp;

    initial forever begin
        @(negedge clock);
        if (oam_rd) begin
            if (exp_addr.size() == 0) chk("oam_addr_unexpected", oam_addr, -1);
            else chk("oam_addr", oam_addr, exp_addr.pop_front());
        end
        if (hold_prev)
            chk("hold_stable", {pix_valid, pix_col, tex_x, tex_y, pix_transparent}, saved);
        if (pix_valid && pix_ready) begin
            if (exp_pix.size() == 0) begin
                chk("pix_unexpected", pix_col, -1);
            end else begin
                mp = exp_pix.pop_front();
                chk("pix_col", pix_col, mp.col);
                chk("tex_x", tex_x, mp.tx);
                chk("tex_y", tex_y, mp.ty);
                chk("pix_transparent", pix_transparent, mp.tr);
            end
            acc_cnt++;
        end
        hold_prev = pix_valid && !pix_ready;
        saved     = {pix_valid, pix_col, tex_x, tex_y, pix_transparent};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, vs, dbl, idx;
        for (int a = 0; a < 512; a++) mem[a] = 16'($urandom);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_zero("reset_outputs");
        reset = 1'b0;

        set_group(1, 'h0100, 0, 0, 'h0100);
        launch(1, 10, 20, 23, 8, 8, 0);
        finish_run(1, 8);

        launch(1, 10, 20, 23, 8, 8, 1);
        finish_run(1, 16);

        set_group(1, 'h0080, 0, 0, 'h0100);
        launch(1, 10, 20, 23, 8, 8, 0);
        finish_run(1, 8);

        set_group(1, 'hFF00, 0, 0, 'h0100);
        launch(1, 10, 20, 23, 8, 8, 0);
        finish_run(1, 8);

        set_group(1, 'h0100, 0, 0, 'h0100);
        rmode = 2;
        launch(1, 10, 20, 23, 8, 8, 0);
        finish_run(0, 8);
        chk("stall_cycles", stall, 3);
        rmode = 0;

        // Reset while pixel 4 is on the bus.
        launch(1, 10, 20, 23, 8, 8, 0);
        for (int k = 0; k < 60; k++) begin
            @(posedge clock);
            #3;
            if (acc_cnt == 4) break;
        end
        chk("reached_pixel4", acc_cnt, 4);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_zero("reset_mid_walk");
        exp_pix.delete();
        exp_addr.delete();
        launch(1, 10, 20, 23, 8, 8, 0);
        finish_run(1, 8);

        // Reset during FETCH.
        launch(7, 100, 5, 9, 16, 8, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_zero("reset_mid_fetch");
        exp_pix.delete();
        exp_addr.delete();

        // Start coinciding with reset is ignored.
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1 begin
            reset = 1'b0;
            start = 1'b0;
        end
        @(negedge clock);
        chk("start_under_reset", busy, 0);
        @(negedge clock);
        chk("start_under_reset_later", busy, 0);

        rmode = 1;
        for (int r = 0; r < 12; r++) begin
            idx = $urandom_range(0, 31);
            hs  = 8 << $urandom_range(0, 3);
            vs  = 8 << $urandom_range(0, 3);
            dbl = $urandom_range(0, 1);
            set_group(idx, $urandom_range(0, 1023) - 512, $urandom_range(0, 1023) - 512,
                      $urandom_range(0, 1023) - 512, $urandom_range(0, 1023) - 512);
            launch(idx, $urandom_range(0, 511), $urandom_range(0, 255),
                   $urandom_range(0, 255), hs, vs, dbl);
            @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            finish_run(0, dbl ? 2 * hs : hs);
        end
        rmode = 0;

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
